serial_to_parallel_rx: RTL and testbench

Deserializer for the single-bit serial stream: samples `serial_data` on every cycle `serial_valid` is high and assembles `width` consecutive bits, LSB first, into one parallel word. It sits at the receive end of the serial link, the inverse of the parallel-to-serial converter. The assembled word goes out through a registered valid/ready output. The block detects stalled partial words (gap timeout) and words lost to back-pressure (overflow).

---
 rtl/serial_pkg.sv | 9 +
 rtl/serial_to_parallel_rx_if.sv | 25 ++
 rtl/valid_ready_hold_reg.sv | 39 +++
 rtl/serial_to_parallel_rx.sv | 84 ++++++++
 tb/tb_serial_to_parallel_rx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Types shared by the serial link receiver and transmitter.
package serial_pkg;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial input, parallel valid/ready output and status flags of the deserializer.
interface serial_to_parallel_rx_if #(
  parameter int width = 8
);

  logic             serial_valid;
  logic             serial_data;
  logic             parallel_valid;
  logic             parallel_ready;
  logic [width-1:0] parallel_data;
  logic             busy;
  logic             frame_error;
  logic             overflow;

  modport master (
    output serial_valid, serial_data, parallel_ready,
    input  parallel_valid, parallel_data, busy, frame_error, overflow
  );

  modport slave (
    input  serial_valid, serial_data, parallel_ready,
    output parallel_valid, parallel_data, busy, frame_error, overflow
  );

endinterface

// File: rtl/valid_ready_hold_reg.sv
// Output word register: holds a loaded word until accepted; a load while full
// and not being accepted is dropped and flagged one cycle later.
module valid_ready_hold_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             overflow
);

  logic accept;
  logic room;

  assign accept = valid && ready;
  // Accepting in the same cycle frees the slot for the incoming word.
  assign room   = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= load && !room;
      if (load && room) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Deserializer: assembles width serial bits (LSB first) into a word, with
// gap-timeout discard of stalled partial words and overflow on a full output.
module serial_to_parallel_rx
  import serial_pkg::*;
#(
  parameter int width       = 8,
  parameter int gap_timeout = 4
) (
  input logic                     clk,
  input logic                     rst,
  serial_to_parallel_rx_if.slave  bus
);

  localparam int CW = $clog2(width);
  localparam int GW = $clog2(gap_timeout + 1);

  rx_state_t        state;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [width-1:0] shreg;
  logic             busy_q;
  logic             frame_error_q;
  logic             word_done;
  logic             gap_hit;
  logic [width-1:0] word;

  assign word_done = bus.serial_valid && (bit_cnt == CW'(width - 1));
  assign gap_hit   = (state == RX_COLLECT) && !bus.serial_valid &&
                     (gap_cnt == GW'(gap_timeout - 1));
  // The final bit is taken straight from the input so the word loads on its own cycle.
  assign word      = {bus.serial_data, shreg[width-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RX_IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      shreg         <= '0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= gap_hit;
      busy_q        <= bus.serial_valid || ((state == RX_COLLECT) && !gap_hit);
      if (bus.serial_valid) begin
        shreg   <= {bus.serial_data, shreg[width-1:1]};
        gap_cnt <= '0;
        if (word_done) begin
          bit_cnt <= '0;
          state   <= RX_IDLE;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          state   <= RX_COLLECT;
        end
      end else if (state == RX_COLLECT) begin
        if (gap_hit) begin
          state   <= RX_IDLE;
          bit_cnt <= '0;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.frame_error = frame_error_q;

  valid_ready_hold_reg #(
    .width (width)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (word_done),
    .load_data (word),
    .ready     (bus.parallel_ready),
    .valid     (bus.parallel_valid),
    .data      (bus.parallel_data),
    .overflow  (bus.overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench: expected words queued at stimulus time, compared against accepted words.
module tb_serial_to_parallel_rx;

  logic clk = 1'b0;
  logic rst;

  serial_to_parallel_rx_if #(.width(8)) bus();

  serial_to_parallel_rx #(
    .width       (8),
    .gap_timeout (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vld_hi = 0, busy_hi = 0, fe_cnt = 0, ovf_cnt = 0;
  int last_hs = 0, prev_hs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle; a word is taken when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.parallel_valid) vld_hi++;
      if (bus.busy)           busy_hi++;
      if (bus.frame_error)    fe_cnt++;
      if (bus.overflow)       ovf_cnt++;
      if (bus.parallel_valid && bus.parallel_ready) begin
        got_q.push_back(bus.parallel_data);
        prev_hs = last_hs;
        last_hs = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step();
      bus.serial_valid = 1'b1;
      bus.serial_data  = w[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.serial_valid = 1'b0;
      bus.serial_data  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 40) begin
      step();
      n++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) check({tag, "_missing"}, got_q.size(), 1);
      else check(tag, got_q.pop_front(), e);
    end
    check({tag, "_extra"}, got_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.parallel_valid, 0);
    check({tag, "_data"},  bus.parallel_data,  0);
    check({tag, "_busy"},  bus.busy,           0);
    check({tag, "_ferr"},  bus.frame_error,    0);
    check({tag, "_ovf"},   bus.overflow,       0);
  endtask

  initial begin
    int b0, v0, o0, f0;
    logic [7:0] w33;
    rst                = 1'b1;
    bus.serial_valid   = 1'b0;
    bus.serial_data    = 1'b0;
    bus.parallel_ready = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    // Single word
    b0 = busy_hi; v0 = vld_hi;
    exp_q.push_back(8'hA5);
    send(8'hA5, 0, 7);
    idle(1);
    check("a5_latency", bus.parallel_valid, 1);
    idle(4);
    check("a5_vld_cycles", vld_hi - v0, 1);
    check("a5_busy_cycles", busy_hi - b0, 8);
    drain("a5");

    // Back-to-back words
    o0 = ovf_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send(8'h3C, 0, 7);
    send(8'hC3, 0, 7);
    idle(4);
    check("b2b_spacing", last_hs - prev_hs, 8);
    check("b2b_ovf", ovf_cnt - o0, 0);
    drain("b2b");

    // Gap within limit
    f0 = fe_cnt;
    exp_q.push_back(8'h5A);
    send(8'h5A, 0, 3);
    idle(3);
    send(8'h5A, 4, 7);
    idle(4);
    check("gap_ok_ferr", fe_cnt - f0, 0);
    drain("gap_ok");

    // Gap timeout discards partial word
    f0 = fe_cnt;
    send(8'h1F, 0, 4);
    idle(4);
    idle(1);
    check("timeout_ferr_pulse", bus.frame_error, 1);
    check("timeout_busy", bus.busy, 0);
    idle(2);
    check("timeout_ferr_count", fe_cnt - f0, 1);
    exp_q.push_back(8'h81);
    send(8'h81, 0, 7);
    idle(4);
    drain("after_timeout");

    // Back-pressure and overflow
    bus.parallel_ready = 1'b0;
    o0 = ovf_cnt;
    exp_q.push_back(8'h11);
    send(8'h11, 0, 7);
    send(8'h22, 0, 7);
    idle(2);
    check("bp_ovf_count", ovf_cnt - o0, 1);
    check("bp_held_data", bus.parallel_data, 8'h11);
    check("bp_held_valid", bus.parallel_valid, 1);
    exp_q.push_back(8'h33);
    w33 = 8'h33;
    send(w33, 0, 6);
    step();
    bus.serial_valid   = 1'b1;
    bus.serial_data    = w33[7];
    bus.parallel_ready = 1'b1;
    idle(1);
    check("sim_load_valid", bus.parallel_valid, 1);
    check("sim_load_data", bus.parallel_data, 8'h33);
    idle(3);
    check("sim_load_ovf", ovf_cnt - o0, 1);
    drain("bp");

    // Reset mid-word
    f0 = fe_cnt;
    send(8'h0F, 0, 3);
    idle(1);
    rst = 1'b1;
    step();
    check_zero("midreset");
    rst = 1'b0;
    idle(6);
    check("midreset_ferr", fe_cnt - f0, 0);
    exp_q.push_back(8'hFF);
    send(8'hFF, 0, 7);
    idle(4);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
